// File: rtl/ahb5_sram_slave_if.sv
// AHB5 slave-side bus bundle for the SRAM slave: address/control, write data
// and the slave's registered response signals.
interface ahb5_sram_slave_if;
    logic        Hselx;
    logic [31:0] Haddr;
    logic        Hwrite;
    logic [2:0]  Hsize;
    logic [1:0]  Htrans;
    logic [2:0]  Hburst;
    logic [3:0]  Hprot;
    logic        Hmastlock;
    logic        Hready;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic        Hresp;
    logic [31:0] Hrdata;

    modport master (
        output Hselx, Haddr, Hwrite, Hsize, Htrans, Hburst, Hprot, Hmastlock,
               Hready, Hwdata,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Hselx, Haddr, Hwrite, Hsize, Htrans, Hburst, Hprot, Hmastlock,
               Hready, Hwdata,
        output Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb5_sram_slave.sv
// AHB5 slave backed by a word-organised SRAM with configurable wait states,
// byte-lane writes, read-after-write forwarding and two-cycle ERROR responses.
module ahb5_sram_slave #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_STATES = 0
) (
    input logic              Hclk,
    input logic              Hreset,
    ahb5_sram_slave_if.slave bus
);
    localparam int          AW         = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);
    localparam logic [2:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_DONE = 3'd2;
    localparam logic [2:0] S_ERR1 = 3'd3;
    localparam logic [2:0] S_ERR2 = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [2:0]    cnt;
    logic [AW+1:0] addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem [MEM_WORDS];
    logic          ready;
    logic          accept;
    logic          legal;
    logic [3:0]    wmask_q;
    logic [AW-1:0] bus_idx;
    logic [AW-1:0] q_idx;
    logic [31:0]   fwd_word;
    logic          unused_bits;

    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    lane_mask = 4'b0001 << lsb;
            3'd1:    lane_mask = lsb[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign ready         = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);
    assign bus.Hreadyout = ready;
    assign bus.Hresp     = (state == S_ERR1) || (state == S_ERR2);
    assign bus.Hrdata    = rdata_q;

    // New address phases are only taken while the previous data phase is completing.
    assign accept  = bus.Hselx && bus.Hready && bus.Htrans[1] && ready;
    assign bus_idx = bus.Haddr[AW+1:2];
    assign q_idx   = addr_q[AW+1:2];
    assign wmask_q = lane_mask(size_q, addr_q[1:0]);

    assign unused_bits = ^{bus.Htrans[0], bus.Hburst, bus.Hprot, bus.Hmastlock};

    always_comb begin
        legal = ({1'b0, bus.Haddr} < ADDR_LIMIT) && (bus.Hsize <= 3'd2);
        if (bus.Hsize == 3'd1 && bus.Haddr[0])
            legal = 1'b0;
        if (bus.Hsize == 3'd2 && bus.Haddr[1:0] != 2'b00)
            legal = 1'b0;
    end

    // A read issued while a write to the same word is still in its data phase
    // sees the write's bytes merged in, since the commit lands on the same edge.
    always_comb begin
        fwd_word = mem[bus_idx];
        if (state == S_DONE && write_q && q_idx == bus_idx) begin
            for (int i = 0; i < 4; i++)
                if (wmask_q[i])
                    fwd_word[8*i +: 8] = bus.Hwdata[8*i +: 8];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (!accept)
                    state_next = S_IDLE;
                else if (!legal)
                    state_next = S_ERR1;
                else if (WAIT_STATES > 0)
                    state_next = S_WAIT;
                else
                    state_next = S_DONE;
            end
            S_WAIT:  if (cnt == 3'd0) state_next = S_DONE;
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Hclk) begin
        if (Hreset) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            rdata_q <= 32'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= bus.Haddr[AW+1:0];
                write_q <= bus.Hwrite;
                size_q  <= bus.Hsize;
            end
            if (state_next == S_WAIT && state != S_WAIT)
                cnt <= WAIT_LOAD;
            else if (state == S_WAIT && cnt != 3'd0)
                cnt <= cnt - 3'd1;
            if (state == S_WAIT && cnt == 3'd0 && !write_q)
                rdata_q <= mem[q_idx];
            else if (WAIT_STATES == 0 && accept && legal && !bus.Hwrite)
                rdata_q <= fwd_word;
        end
    end

    // Storage is never cleared; a reset on the commit edge drops the pending write.
    always_ff @(posedge Hclk) begin
        if (!Hreset && state == S_DONE && write_q) begin
            for (int i = 0; i < 4; i++)
                if (wmask_q[i])
                    mem[q_idx][8*i +: 8] <= bus.Hwdata[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_ahb5_sram_slave.sv
// Scoreboard bench for ahb5_sram_slave: one instance with no wait states and
// one with three, driven one at a time through a shared master model.
module tb_ahb5_sram_slave;
    localparam int MEM_WORDS = 256;
    localparam int AWT       = 8;

    typedef struct {
        logic        is_read;
        logic        err;
        int          waits;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        sel;
    logic        hselx;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hready_ovr;

    exp_t        sb[$];
    exp_t        e_mon;
    logic [31:0] model [2][MEM_WORDS];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        active = 1'b0;
    int          waits = 0;

    logic        ready_s;
    logic        resp_s;
    logic [31:0] rdata_s;
    logic        acc_s;

    always #5 clk = ~clk;

    ahb5_sram_slave_if bus0();
    ahb5_sram_slave_if bus3();

    assign bus0.Hselx     = hselx & ~sel;
    assign bus0.Haddr     = haddr;
    assign bus0.Hwrite    = hwrite;
    assign bus0.Hsize     = hsize;
    assign bus0.Htrans    = htrans;
    assign bus0.Hburst    = 3'd0;
    assign bus0.Hprot     = 4'd3;
    assign bus0.Hmastlock = 1'b0;
    assign bus0.Hready    = hready_ovr ? 1'b0 : bus0.Hreadyout;
    assign bus0.Hwdata    = hwdata;

    assign bus3.Hselx     = hselx & sel;
    assign bus3.Haddr     = haddr;
    assign bus3.Hwrite    = hwrite;
    assign bus3.Hsize     = hsize;
    assign bus3.Htrans    = htrans;
    assign bus3.Hburst    = 3'd1;
    assign bus3.Hprot     = 4'd3;
    assign bus3.Hmastlock = 1'b0;
    assign bus3.Hready    = hready_ovr ? 1'b0 : bus3.Hreadyout;
    assign bus3.Hwdata    = hwdata;

    assign ready_s = sel ? bus3.Hreadyout : bus0.Hreadyout;
    assign resp_s  = sel ? bus3.Hresp : bus0.Hresp;
    assign rdata_s = sel ? bus3.Hrdata : bus0.Hrdata;
    assign acc_s   = sel ? (bus3.Hselx & bus3.Hready & bus3.Htrans[1])
                         : (bus0.Hselx & bus0.Hready & bus0.Htrans[1]);

    ahb5_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(0)) dut0 (
        .Hclk(clk), .Hreset(hreset), .bus(bus0));
    ahb5_sram_slave #(.MEM_WORDS(MEM_WORDS), .WAIT_STATES(3)) dut3 (
        .Hclk(clk), .Hreset(hreset), .bus(bus3));

    // Data-phase monitor: counts wait cycles and pops one expectation per completion.
    always @(negedge clk) begin
        if (hreset) begin
            active = 1'b0;
            sb.delete();
        end else begin
            if (active) begin
                if (ready_s) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("[TB] FAIL sb_underflow: completion with no expectation queued");
                    end else begin
                        e_mon = sb.pop_front();
                        n_cmp++;
                        if (resp_s !== e_mon.err) begin
                            n_bad++;
                            $display("[TB] FAIL resp: got %b expected %b", resp_s, e_mon.err);
                        end
                        n_cmp++;
                        if (waits !== e_mon.waits) begin
                            n_bad++;
                            $display("[TB] FAIL wait_cycles: got %0d expected %0d", waits, e_mon.waits);
                        end
                        if (e_mon.is_read && !e_mon.err) begin
                            n_cmp++;
                            if (rdata_s !== e_mon.data) begin
                                n_bad++;
                                $display("[TB] FAIL rdata: got %h expected %h", rdata_s, e_mon.data);
                            end
                        end
                    end
                    active = 1'b0;
                end else begin
                    waits++;
                    if (sb.size() > 0) begin
                        n_cmp++;
                        if (resp_s !== sb[0].err) begin
                            n_bad++;
                            $display("[TB] FAIL wait_resp: got %b expected %b", resp_s, sb[0].err);
                        end
                    end
                end
            end
            if (acc_s) begin
                active = 1'b1;
                waits  = 0;
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                        input logic [31:0] wdata);
        exp_t       e;
        logic       ok;
        logic [3:0] m;
        int         s;
        bit         got;
        s = sel ? 1 : 0;
        hselx = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = 2'd2;
        ok = ({1'b0, addr} < 33'(4 * MEM_WORDS)) && (size <= 3'd2)
             && !(size == 3'd1 && addr[0]) && !(size == 3'd2 && addr[1:0] != 2'b00);
        case (size)
            3'd0:    m = 4'b0001 << addr[1:0];
            3'd1:    m = addr[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        e.is_read = !wr;
        e.err     = !ok;
        e.waits   = !ok ? 1 : (sel ? 3 : 0);
        e.data    = 32'd0;
        if (ok && wr)
            for (int i = 0; i < 4; i++)
                if (m[i]) model[s][addr[AWT+1:2]][8*i +: 8] = wdata[8*i +: 8];
        if (ok && !wr)
            e.data = model[s][addr[AWT+1:2]];
        sb.push_back(e);
        got = 0;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge clk);
            if (sel ? bus3.Hready : bus0.Hready) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("[TB] FAIL accept_timeout: got no Hready expected Hready=1 within 32 cycles");
        end
        @(posedge clk); #1;
        hwdata = wdata;
    endtask

    task automatic idle_bus();
        htrans = 2'd0;
        hselx  = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #2;
            if (sb.size() == 0 && !active) done = 1;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (bus0.Hreadyout !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_ready0: got %b expected 1", bus0.Hreadyout); end
        n_cmp++; if (bus0.Hresp !== 1'b0)     begin n_bad++; $display("[TB] FAIL rst_resp0: got %b expected 0", bus0.Hresp); end
        n_cmp++; if (bus0.Hrdata !== 32'd0)   begin n_bad++; $display("[TB] FAIL rst_rdata0: got %h expected 0", bus0.Hrdata); end
        n_cmp++; if (bus3.Hreadyout !== 1'b1) begin n_bad++; $display("[TB] FAIL rst_ready3: got %b expected 1", bus3.Hreadyout); end
        n_cmp++; if (bus3.Hresp !== 1'b0)     begin n_bad++; $display("[TB] FAIL rst_resp3: got %b expected 0", bus3.Hresp); end
        n_cmp++; if (bus3.Hrdata !== 32'd0)   begin n_bad++; $display("[TB] FAIL rst_rdata3: got %h expected 0", bus3.Hrdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        xfer(32'h14, 1'b1, 3'd2, 32'h12345678);
        xfer(32'h14, 1'b0, 3'd2, 32'h0);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
    endtask

    task automatic test_byte_lanes();
        sel = 1'b0;
        xfer(32'h10, 1'b1, 3'd2, 32'h11223344);
        xfer(32'h13, 1'b1, 3'd0, 32'hAA000000);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        xfer(32'h12, 1'b1, 3'd1, 32'h55660000);
        xfer(32'h10, 1'b0, 3'd2, 32'h0);
        xfer(32'h10, 1'b1, 3'd0, 32'h000000C3);
        xfer(32'h11, 1'b0, 3'd0, 32'h0);
        idle_bus();
        drain();
    endtask

    task automatic test_wait_states();
        sel = 1'b1;
        xfer(32'h20, 1'b1, 3'd2, 32'h01020304);
        xfer(32'h20, 1'b0, 3'd2, 32'h0);
        xfer(32'h22, 1'b1, 3'd1, 32'hBEEF0000);
        xfer(32'h20, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
    endtask

    task automatic test_illegal();
        sel = 1'b0;
        xfer(32'h0, 1'b1, 3'd2, 32'h11112222);
        xfer(32'h3FC, 1'b1, 3'd2, 32'h0A0B0C0D);
        xfer(32'h2, 1'b1, 3'd2, 32'hDEAD0000);
        xfer(32'h400, 1'b1, 3'd0, 32'h000000EE);
        xfer(32'h0, 1'b1, 3'd3, 32'h99999999);
        xfer(32'h1, 1'b1, 3'd1, 32'h0000BB00);
        xfer(32'h3FF, 1'b1, 3'd0, 32'h77000000);
        xfer(32'h3FC, 1'b0, 3'd2, 32'h0);
        xfer(32'h0, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
        sel = 1'b1;
        xfer(32'h400, 1'b0, 3'd2, 32'h0);
        xfer(32'h24, 1'b1, 3'd2, 32'hA5A5F00F);
        xfer(32'h26, 1'b0, 3'd2, 32'h0);
        xfer(32'h24, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
    endtask

    task automatic test_idle_busy();
        sel = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 2) begin
                hselx = 1'b1; htrans = 2'd0;
            end else if (c < 4) begin
                htrans = 2'd1;
            end else if (c < 6) begin
                htrans = 2'd2; hwrite = 1'b1; haddr = 32'h0; hsize = 3'd2;
                hwdata = 32'hFFFFFFFF; hready_ovr = 1'b1;
            end else begin
                hready_ovr = 1'b0; hselx = 1'b0;
            end
            @(negedge clk);
            n_cmp++;
            if (ready_s !== 1'b1) begin n_bad++; $display("[TB] FAIL idle_ready: got %b expected 1 (cycle %0d)", ready_s, c); end
            n_cmp++;
            if (resp_s !== 1'b0) begin n_bad++; $display("[TB] FAIL idle_resp: got %b expected 0 (cycle %0d)", resp_s, c); end
            @(posedge clk); #1;
        end
        idle_bus();
        xfer(32'h0, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] saved;
        sel = 1'b1;
        xfer(32'h40, 1'b1, 3'd2, 32'h01020304);
        xfer(32'h40, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
        saved = model[1][16];
        xfer(32'h40, 1'b1, 3'd2, 32'hCAFEF00D);
        idle_bus();
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus3.Hreadyout !== 1'b1) begin n_bad++; $display("[TB] FAIL midrst_ready: got %b expected 1", bus3.Hreadyout); end
        n_cmp++; if (bus3.Hresp !== 1'b0)     begin n_bad++; $display("[TB] FAIL midrst_resp: got %b expected 0", bus3.Hresp); end
        n_cmp++; if (bus3.Hrdata !== 32'd0)   begin n_bad++; $display("[TB] FAIL midrst_rdata: got %h expected 0", bus3.Hrdata); end
        @(posedge clk); #1;
        model[1][16] = saved;
        repeat (4) begin @(posedge clk); #1; end
        xfer(32'h40, 1'b0, 3'd2, 32'h0);
        idle_bus();
        drain();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        hreset = 1'b1; sel = 1'b0; hselx = 1'b0; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'd0; htrans = 2'd0; hwdata = 32'h0; hready_ovr = 1'b0;
        repeat (3) @(posedge clk);
        #1 hreset = 1'b0;
        test_reset();
        test_back_to_back();
        test_byte_lanes();
        test_wait_states();
        test_illegal();
        test_idle_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
